// File: rtl/sticky_loop_ctrl.sv
// sticky_loop_ctrl: two-slot sticky OR-feedback loop with phase-aware round-robin injection and masked clear.
module sticky_loop_ctrl #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_slot,
  output logic [NREQ-1:0] gnt,
  input  logic            clr_req,
  input  logic [1:0]      clr_mask,
  output logic            clr_busy,
  output logic            ph,
  output logic            yout,
  output logic [1:0]      slot_sts
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NR = (PW+1)'(NREQ);
  typedef enum logic [1:0] {RUN, CLR0, CLR1} state_t;
  state_t state, state_nx;
  logic stage_a, stage_b, xin;
  logic [PW-1:0] rr_ptr, rr_nx;
  logic [1:0] mask;
  logic [NREQ-1:0] elig;
  // injecting at phase p lands in slot p^1, so a requester needs req_slot == ~ph
  assign elig = req & (ph ? ~req_slot : req_slot);
  assign xin = |gnt;
  always_comb begin
    logic [PW:0] sum;
    logic [PW:0] nxt;
    logic [PW-1:0] idx;
    gnt = '0;
    rr_nx = rr_ptr;
    sum = '0;
    nxt = '0;
    idx = '0;
    if (state == RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rr_ptr} + (PW+1)'(k);
        sum = (sum >= NR) ? sum - NR : sum;
        idx = sum[PW-1:0];
        if (elig[idx] && gnt == '0) begin
          gnt[idx] = 1'b1;
          nxt = {1'b0, idx} + (PW+1)'(1);
          rr_nx = (nxt == NR) ? '0 : nxt[PW-1:0];
        end
      end
      state_nx = clr_req ? CLR0 : RUN;
    end else begin
      state_nx = (state == CLR0) ? CLR1 : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      stage_a <= 1'b0;
      stage_b <= 1'b0;
      ph      <= 1'b0;
      rr_ptr  <= '0;
      mask    <= '0;
    end else begin
      state   <= state_nx;
      ph      <= ~ph;
      rr_ptr  <= rr_nx;
      stage_a <= stage_b;
      stage_b <= (state == RUN) ? (stage_a | xin) : (stage_a & ~mask[~ph]);
      if (state == RUN && clr_req) mask <= clr_mask;
    end
  end
  assign clr_busy = (state != RUN);
  assign yout     = stage_b;
  assign slot_sts = ph ? {stage_b, stage_a} : {stage_a, stage_b};
endmodule

// File: tb/tb_sticky_loop_ctrl.sv
// tb_sticky_loop_ctrl: directed and random stimulus against a slot-level reference model.
module tb_sticky_loop_ctrl;
  localparam int NREQ = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req = '0, req_slot = '0, gnt;
  logic clr_req = 1'b0;
  logic [1:0] clr_mask = '0;
  logic clr_busy, ph, yout;
  logic [1:0] slot_sts;
  int errs = 0, checks = 0;
  bit m_slot[2];
  int m_ph, m_rr, m_cnt;
  bit [1:0] m_mask;
  always #5 clk = ~clk;
  sticky_loop_ctrl #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_slot(req_slot), .gnt(gnt),
    .clr_req(clr_req), .clr_mask(clr_mask), .clr_busy(clr_busy), .ph(ph),
    .yout(yout), .slot_sts(slot_sts)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_slot[0] = 0; m_slot[1] = 0;
    m_ph = 0; m_rr = 0; m_cnt = 0; m_mask = 0;
  endtask
  function automatic logic [NREQ-1:0] m_gnt();
    logic [NREQ-1:0] g = '0;
    if (m_cnt != 0) return g;
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_rr + k) % NREQ;
      if (req[i] && req_slot[i] == (m_ph == 0)) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction
  task automatic step();
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = m_gnt();
    chk("gnt", int'(gnt), int'(g));
    chk("onehot", int'($countones(gnt) <= 1), 1);
    chk("ph", int'(ph), m_ph);
    chk("yout", int'(yout), int'(m_slot[m_ph]));
    chk("slot_sts", int'(slot_sts), int'({m_slot[1], m_slot[0]}));
    chk("clr_busy", int'(clr_busy), int'(m_cnt != 0));
    if (m_cnt > 0) begin
      if (m_mask[m_ph ^ 1]) m_slot[m_ph ^ 1] = 0;
      m_cnt--;
    end else begin
      if (g != 0) begin
        for (int i = 0; i < NREQ; i++) if (g[i]) m_rr = (i + 1) % NREQ;
        m_slot[m_ph ^ 1] = 1;
      end
      if (clr_req) begin
        m_cnt = 2;
        m_mask = clr_mask;
      end
    end
    m_ph ^= 1;
    @(posedge clk);
    #1;
  endtask
  task automatic align(input int p);
    while (m_ph != p) step();
  endtask
  initial begin
    m_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_slot_sts", int'(slot_sts), 0);
      chk("rst_yout", int'(yout), 0);
      chk("rst_ph", int'(ph), 0);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_clr_busy", int'(clr_busy), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) step();
    req_slot = 4'b1111;
    align(0);
    req = 4'b0001;
    step();
    req = '0;
    repeat (4) step();
    align(0);
    req_slot = 4'b1011;
    req = 4'b0100;
    step();
    step();
    req = '0;
    repeat (2) step();
    req_slot = 4'b1111;
    req = 4'b1111;
    repeat (10) step();
    req = '0;
    clr_req = 1'b1;
    clr_mask = 2'b01;
    step();
    clr_req = 1'b0;
    req = 4'b1111;
    step();
    clr_req = 1'b1;
    clr_mask = 2'b11;
    step();
    clr_req = 1'b0;
    step();
    req = '0;
    repeat (2) step();
    align(0);
    req = 4'b0001;
    req_slot = 4'b1111;
    clr_req = 1'b1;
    clr_mask = 2'b11;
    step();
    req = '0;
    clr_req = 1'b0;
    repeat (3) step();
    req = 4'b0011;
    req_slot = 4'b0010;
    repeat (2) step();
    req = '0;
    clr_req = 1'b1;
    clr_mask = 2'b11;
    step();
    clr_req = 1'b0;
    chk("pre_abort_busy", int'(clr_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_slot_sts", int'(slot_sts), 0);
    chk("abort_clr_busy", int'(clr_busy), 0);
    chk("abort_yout", int'(yout), 0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();
    repeat (400) begin
      req = NREQ'($urandom);
      req_slot = NREQ'($urandom);
      clr_req = ($urandom_range(0, 7) == 0);
      clr_mask = 2'($urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
